track_lookup_arbiter: RTL and testbench
=======================================

Name: track_lookup_arbiter

Overview:
- Shares the single read port of the track tile/obstacle BRAM between the racer view renderer and two game-logic requesters: player and opponent collision/surface queries.
- The renderer owns the RAM during the active video region and is never stalled.
- Game-logic lookups are served during blanking through a req/ack handshake, with round-robin arbitration between the two requesters.
- Sits between the track BRAM and both the racer view pipeline and the kart physics blocks.

Parameters:
ADDR_W, 8, track RAM address width ({tile_y[3:0], tile_x[3:0]})
DATA_W, 8, track RAM word width ({obstacle_type[3:0], sprite_type[3:0]})
H_ACTIVE, 1024, first hcount value that is horizontal blanking
V_ACTIVE, 768, first vcount value that is vertical blanking
RAM_LAT, 2, BRAM read latency in cycles; must be ≥ 1

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
hcount_in  input  11  current pixel column
vcount_in  input  10  current pixel row
render_addr_in  input  ADDR_W  renderer tile address, valid every active cycle
render_data_out  output  DATA_W  tile word for the renderer
render_valid_out  output  1  render_data_out corresponds to an active-region address
p0_req_in  input  1  player lookup request
p0_addr_in  input  ADDR_W  player lookup address; held stable while p0_req_in is high
p0_ack_out  output  1  one-cycle pulse: p0_data_out valid
p0_data_out  output  DATA_W  player lookup result
p1_req_in  input  1  opponent lookup request
p1_addr_in  input  ADDR_W  opponent lookup address; held stable while p1_req_in is high
p1_ack_out  output  1  one-cycle pulse: p1_data_out valid
p1_data_out  output  DATA_W  opponent lookup result
ram_addr_out  output  ADDR_W  address to track BRAM
ram_data_in  input  DATA_W  BRAM read data, RAM_LAT cycles after address

Behaviour:
- Clock and reset: one clock (clk_in); reset is synchronous and active-high (rst_in).
- blank = (hcount_in ≥ H_ACTIVE) || (vcount_in ≥ V_ACTIVE); active = !blank.

Renderer path:
- ram_addr_out is a combinational mux.
- While active: ram_addr_out = render_addr_in.
- While blank: ram_addr_out = the granted requester's address in the grant cycle, otherwise the last address driven.
- render_data_out = ram_data_in, combinational passthrough.
- render_valid_out = active delayed by RAM_LAT cycles through a shift register. Total renderer latency equals RAM_LAT with no extra cycles.

Arbiter FSM, states IDLE and WAIT:
- IDLE → WAIT on a cycle that is blank with p0_req_in or p1_req_in high (the grant cycle).
  - Only one requester high: that one is granted.
  - Both high: the one not granted last time wins (round-robin). rr_last resets to 1, so p0 wins the first tie.
  - In the grant cycle, ram_addr_out = granted requester's addr; latch the grant id; update rr_last; wait counter = RAM_LAT.
- WAIT: counter decrements each cycle. When counter reaches 0, ram_data_in is the lookup result. On that cycle:
  - register it into pX_data_out;
  - pulse pX_ack_out high on the next cycle;
  - return to IDLE.
- Ack arrives exactly RAM_LAT+1 cycles after the grant cycle.
- No new grant while in WAIT: one outstanding lookup at a time.
- The IDLE state entered on the ack cycle may grant that same cycle, giving a maximum of one lookup per RAM_LAT+1 cycles.

Handshake rules:
- Requester drops req on the cycle it sees ack. If req is still high the cycle after ack, it is a new request.
- A req deasserted after its grant still completes and acks.
- A req raised during active waits until the first blank cycle.
- A grant issued on the last blank cycle before active still completes correctly, because the BRAM sampled the address in the grant cycle. The renderer regains ram_addr_out the following cycle.
- hcount/vcount wrap at frame end needs no special handling.

Output values and reset:
- pX_data_out holds its value between acks.
- On reset, all of the following go to 0: ack outputs, data outputs, render_valid shift register, counter. State = IDLE, rr_last = 1.
- An in-flight lookup at reset is discarded and produces no ack.

Test Plan:
- Renderer only: sweep hcount 1020..1027 at vcount=10, render_addr_in = hcount[7:0], RAM model with data = addr ^ 8'hA5 -> render_valid_out high for the results of hcount 1020..1023 (2 cycles later each), low thereafter; render_data_out matches the model.
- p0 request at hcount=500 (active), addr 8'h3C -> no grant until hcount=1024; ram_addr_out = 8'h3C at hcount=1024; p0_ack_out pulses at hcount=1027 with p0_data_out = 8'h99; p1_ack_out stays 0.
- p0 and p1 raised together in blank (addrs 8'h11, 8'h22), both re-request after ack -> grant order p0, p1, p0, p1; acks spaced 3 cycles apart; data 8'hB4, 8'h87.
- Grant issued at hcount=1343 (last blank column of a 1344-wide line) with vcount in active rows, p1 addr 8'h7F -> p1_ack_out at hcount=2 of the next line with 8'hDA; render_valid_out resumes 2 cycles after hcount=0.
- Assert rst_in one cycle after a p0 grant -> no p0_ack_out ever appears for that lookup; state IDLE, rr_last=1; a new p0/p1 tie after reset grants p0.
- Vertical blanking, vcount=770, p1 held high continuously -> a new grant every 3 cycles, acks at 3-cycle spacing, ram_addr_out = p1_addr_in on each grant cycle.

Source files
------------

// File: rtl/track_lookup_arbiter.sv
// track_lookup_arbiter
// Shares the single read port of the track tile/obstacle BRAM. The racer view
// renderer owns the port during active video. The player and opponent lookups
// are served during blanking through a req/ack handshake with round-robin
// arbitration and one outstanding lookup at a time.
module track_lookup_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter int RAM_LAT  = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic [ADDR_W-1:0] render_addr_in,
    output logic [DATA_W-1:0] render_data_out,
    output logic              render_valid_out,
    input  logic              p0_req_in,
    input  logic [ADDR_W-1:0] p0_addr_in,
    output logic              p0_ack_out,
    output logic [DATA_W-1:0] p0_data_out,
    input  logic              p1_req_in,
    input  logic [ADDR_W-1:0] p1_addr_in,
    output logic              p1_ack_out,
    output logic [DATA_W-1:0] p1_data_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    input  logic [DATA_W-1:0] ram_data_in
);

    localparam int CNT_W = $clog2(RAM_LAT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    logic              blank;
    logic              active;
    logic              any_req;
    logic              grant_p1;
    logic              grant_now;
    logic              lookup_done;
    logic              rr_last;
    logic              grant_id;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [RAM_LAT-1:0] valid_sr;

    assign blank   = (hcount_in >= 11'(H_ACTIVE)) || (vcount_in >= 10'(V_ACTIVE));
    assign active  = ~blank;
    assign any_req = p0_req_in | p1_req_in;

    // rr_last = 1 means p1 won last, so on a tie p1 only wins when p0 won last.
    assign grant_p1 = p1_req_in & (~p0_req_in | ~rr_last);

    assign render_data_out  = ram_data_in;
    assign render_valid_out = valid_sr[RAM_LAT-1];

    // State register for the lookup arbiter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: grant in blanking when someone asks, return once the BRAM data is due.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (blank && any_req) state_next = ST_WAIT;
            ST_WAIT: if (wait_cnt == CNT_W'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs of the FSM plus the BRAM address mux (renderer always wins during active).
    always_comb begin
        grant_now    = 1'b0;
        lookup_done  = 1'b0;
        ram_addr_out = last_addr;
        case (state)
            ST_IDLE: grant_now   = blank & any_req;
            ST_WAIT: lookup_done = (wait_cnt == CNT_W'(1));
            default: ;
        endcase
        if (active) begin
            ram_addr_out = render_addr_in;
        end else if (grant_now) begin
            ram_addr_out = grant_p1 ? p1_addr_in : p0_addr_in;
        end
    end

    // Grant bookkeeping, latency countdown, result capture and the ack pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_last     <= 1'b1;
            grant_id    <= 1'b0;
            wait_cnt    <= '0;
            p0_ack_out  <= 1'b0;
            p1_ack_out  <= 1'b0;
            p0_data_out <= '0;
            p1_data_out <= '0;
        end else begin
            p0_ack_out <= lookup_done & ~grant_id;
            p1_ack_out <= lookup_done & grant_id;
            if (grant_now) begin
                grant_id <= grant_p1;
                rr_last  <= grant_p1;
                wait_cnt <= CNT_W'(RAM_LAT);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (lookup_done) begin
                if (grant_id) begin
                    p1_data_out <= ram_data_in;
                end else begin
                    p0_data_out <= ram_data_in;
                end
            end
        end
    end

    // Remember the address last presented so blanking cycles without a grant hold it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_addr <= '0;
        end else begin
            last_addr <= ram_addr_out;
        end
    end

    // Delay the active flag by the BRAM latency so valid lines up with render_data_out.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= (valid_sr << 1) | RAM_LAT'(active);
        end
    end

endmodule

// File: tb/tb_track_lookup_arbiter.sv
// tb_track_lookup_arbiter
// Self-checking bench: directed scenarios plus a randomized run checked
// against a transaction-level model (grant slots, round-robin, ack timing).
module tb_track_lookup_arbiter;

    localparam int RAM_LAT = 2;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  render_addr;
    logic [7:0]  render_data;
    logic        render_valid;
    logic        p0_req, p1_req;
    logic [7:0]  p0_addr, p1_addr;
    logic        p0_ack, p1_ack;
    logic [7:0]  p0_data, p1_data;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_data;
    logic [7:0]  pipe0, pipe1;

    int n_cmp  = 0;
    int n_fail = 0;

    track_lookup_arbiter #(
        .ADDR_W(8), .DATA_W(8), .H_ACTIVE(1024), .V_ACTIVE(768), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
        .render_addr_in(render_addr), .render_data_out(render_data),
        .render_valid_out(render_valid),
        .p0_req_in(p0_req), .p0_addr_in(p0_addr), .p0_ack_out(p0_ack), .p0_data_out(p0_data),
        .p1_req_in(p1_req), .p1_addr_in(p1_addr), .p1_ack_out(p1_ack), .p1_data_out(p1_data),
        .ram_addr_out(ram_addr), .ram_data_in(ram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Track BRAM model: two-cycle read latency, contents = addr ^ 8'hA5.
    always @(posedge clk) begin
        pipe0 <= ram_addr;
        pipe1 <= pipe0;
    end
    assign ram_data = pipe1 ^ 8'hA5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hcount = '0; vcount = '0; render_addr = '0;
        p0_req = 1'b0; p1_req = 1'b0; p0_addr = '0; p1_addr = '0;
        repeat (3) tick();
        n_cmp++; if (p0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_p0_ack: got %b want 0", p0_ack); end
        n_cmp++; if (p1_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_p1_ack: got %b want 0", p1_ack); end
        n_cmp++; if (p0_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_p0_data: got %h want 00", p0_data); end
        n_cmp++; if (p1_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_p1_data: got %h want 00", p1_data); end
        n_cmp++; if (render_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_render_valid: got %b want 0", render_valid); end
        rst = 1'b0;
    endtask

    task automatic test_renderer();
        logic [10:0] hs [10];
        vcount = 10'd10;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) begin
                n_cmp++;
                if (render_valid !== (hs[i-2] < 11'd1024)) begin
                    n_fail++; $display("[TB] FAIL render_valid h=%0d: got %b want %b", hs[i-2], render_valid, hs[i-2] < 11'd1024);
                end
                if (hs[i-2] < 11'd1024) begin
                    n_cmp++;
                    if (render_data !== (hs[i-2][7:0] ^ 8'hA5)) begin
                        n_fail++; $display("[TB] FAIL render_data h=%0d: got %h want %h", hs[i-2], render_data, hs[i-2][7:0] ^ 8'hA5);
                    end
                end
            end
            hs[i] = 11'(1020 + i);
            hcount = hs[i];
            render_addr = hs[i][7:0];
            #1;
            if (hs[i] < 11'd1024) begin
                n_cmp++; if (ram_addr !== hs[i][7:0]) begin n_fail++; $display("[TB] FAIL render_addr_mux: got %h want %h", ram_addr, hs[i][7:0]); end
            end else begin
                n_cmp++; if (ram_addr !== 8'hFF) begin n_fail++; $display("[TB] FAIL blank_hold_addr: got %h want ff", ram_addr); end
            end
        end
    endtask

    task automatic test_round_robin();
        int n0 = 0;
        int n1 = 0;
        vcount = 10'd10; hcount = 11'd1100;
        p0_addr = 8'h11; p1_addr = 8'h22;
        for (int k = 0; k < 14; k++) begin
            bit e0, e1;
            tick();
            e0 = (k == 3) || (k == 9);
            e1 = (k == 6) || (k == 12);
            n_cmp++; if (p0_ack !== e0) begin n_fail++; $display("[TB] FAIL rr_p0_ack k=%0d: got %b want %b", k, p0_ack, e0); end
            n_cmp++; if (p1_ack !== e1) begin n_fail++; $display("[TB] FAIL rr_p1_ack k=%0d: got %b want %b", k, p1_ack, e1); end
            if (e0) begin n_cmp++; if (p0_data !== 8'hB4) begin n_fail++; $display("[TB] FAIL rr_p0_data: got %h want b4", p0_data); end end
            if (e1) begin n_cmp++; if (p1_data !== 8'h87) begin n_fail++; $display("[TB] FAIL rr_p1_data: got %h want 87", p1_data); end end
            if (p0_ack) begin p0_req = 1'b0; n0++; end else if (n0 < 2) p0_req = 1'b1;
            if (p1_ack) begin p1_req = 1'b0; n1++; end else if (n1 < 2) p1_req = 1'b1;
            #1;
            if (k == 0 || k == 6) begin
                n_cmp++; if (ram_addr !== 8'h11) begin n_fail++; $display("[TB] FAIL rr_grant_p0 k=%0d: got %h want 11", k, ram_addr); end
            end
            if (k == 3 || k == 9) begin
                n_cmp++; if (ram_addr !== 8'h22) begin n_fail++; $display("[TB] FAIL rr_grant_p1 k=%0d: got %h want 22", k, ram_addr); end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    task automatic test_active_wait();
        int hl [9];
        hl = '{500, 501, 1022, 1023, 1024, 1025, 1026, 1027, 1028};
        vcount = 10'd10; p0_addr = 8'h3C;
        for (int i = 0; i < 9; i++) begin
            bit e0;
            tick();
            e0 = (hl[i] == 1027);
            n_cmp++; if (p0_ack !== e0) begin n_fail++; $display("[TB] FAIL aw_p0_ack h=%0d: got %b want %b", hl[i], p0_ack, e0); end
            n_cmp++; if (p1_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL aw_p1_ack h=%0d: got %b want 0", hl[i], p1_ack); end
            if (e0) begin
                n_cmp++; if (p0_data !== 8'h99) begin n_fail++; $display("[TB] FAIL aw_p0_data: got %h want 99", p0_data); end
                p0_req = 1'b0;
            end
            if (i == 0) p0_req = 1'b1;
            hcount = 11'(hl[i]);
            render_addr = 8'($urandom);
            #1;
            if (hl[i] < 1024) begin
                n_cmp++; if (ram_addr !== render_addr) begin n_fail++; $display("[TB] FAIL aw_render_owns h=%0d: got %h want %h", hl[i], ram_addr, render_addr); end
            end
            if (hl[i] == 1024) begin
                n_cmp++; if (ram_addr !== 8'h3C) begin n_fail++; $display("[TB] FAIL aw_grant_addr: got %h want 3c", ram_addr); end
            end
        end
    endtask

    task automatic test_last_blank_column();
        int         hl [9];
        logic [7:0] ra [9];
        hl = '{1340, 1341, 1342, 1343, 0, 1, 2, 3, 4};
        vcount = 10'd10; p1_addr = 8'h7F;
        for (int i = 0; i < 9; i++) begin
            bit e1;
            tick();
            e1 = (i == 6);
            n_cmp++; if (p1_ack !== e1) begin n_fail++; $display("[TB] FAIL lb_p1_ack i=%0d: got %b want %b", i, p1_ack, e1); end
            n_cmp++; if (p0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL lb_p0_ack i=%0d: got %b want 0", i, p0_ack); end
            n_cmp++; if (render_valid !== (i >= 6)) begin n_fail++; $display("[TB] FAIL lb_render_valid i=%0d: got %b want %b", i, render_valid, i >= 6); end
            if (e1) begin
                n_cmp++; if (p1_data !== 8'hDA) begin n_fail++; $display("[TB] FAIL lb_p1_data: got %h want da", p1_data); end
                p1_req = 1'b0;
            end
            if (i >= 6) begin
                n_cmp++; if (render_data !== (ra[i-2] ^ 8'hA5)) begin n_fail++; $display("[TB] FAIL lb_render_data i=%0d: got %h want %h", i, render_data, ra[i-2] ^ 8'hA5); end
            end
            if (i == 3) p1_req = 1'b1;
            hcount = 11'(hl[i]);
            render_addr = 8'($urandom);
            ra[i] = render_addr;
            #1;
            if (i == 3) begin
                n_cmp++; if (ram_addr !== 8'h7F) begin n_fail++; $display("[TB] FAIL lb_grant_addr: got %h want 7f", ram_addr); end
            end
            if (i >= 4) begin
                n_cmp++; if (ram_addr !== render_addr) begin n_fail++; $display("[TB] FAIL lb_render_regain i=%0d: got %h want %h", i, ram_addr, render_addr); end
            end
        end
    endtask

    task automatic test_reset_inflight();
        vcount = 10'd770; hcount = 11'd100;
        for (int k = 0; k < 11; k++) begin
            bit e0, e1;
            tick();
            e0 = (k == 6);
            e1 = (k == 9);
            n_cmp++; if (p0_ack !== e0) begin n_fail++; $display("[TB] FAIL ri_p0_ack k=%0d: got %b want %b", k, p0_ack, e0); end
            n_cmp++; if (p1_ack !== e1) begin n_fail++; $display("[TB] FAIL ri_p1_ack k=%0d: got %b want %b", k, p1_ack, e1); end
            if (k == 2) begin
                n_cmp++; if (p0_data !== 8'h00) begin n_fail++; $display("[TB] FAIL ri_p0_data_cleared: got %h want 00", p0_data); end
                n_cmp++; if (p1_data !== 8'h00) begin n_fail++; $display("[TB] FAIL ri_p1_data_cleared: got %h want 00", p1_data); end
            end
            if (e0) begin
                n_cmp++; if (p0_data !== 8'hE1) begin n_fail++; $display("[TB] FAIL ri_p0_data: got %h want e1", p0_data); end
                p0_req = 1'b0;
            end
            if (e1) begin
                n_cmp++; if (p1_data !== 8'hF0) begin n_fail++; $display("[TB] FAIL ri_p1_data: got %h want f0", p1_data); end
                p1_req = 1'b0;
            end
            case (k)
                0: begin p0_req = 1'b1; p0_addr = 8'h33; end
                1: begin rst = 1'b1; p0_req = 1'b0; end
                2: rst = 1'b0;
                3: begin p0_req = 1'b1; p0_addr = 8'h44; p1_req = 1'b1; p1_addr = 8'h55; end
                default: ;
            endcase
            #1;
            if (k == 0) begin n_cmp++; if (ram_addr !== 8'h33) begin n_fail++; $display("[TB] FAIL ri_first_grant: got %h want 33", ram_addr); end end
            if (k == 3) begin n_cmp++; if (ram_addr !== 8'h44) begin n_fail++; $display("[TB] FAIL ri_tie_after_reset: got %h want 44", ram_addr); end end
            if (k == 6) begin n_cmp++; if (ram_addr !== 8'h55) begin n_fail++; $display("[TB] FAIL ri_p1_grant: got %h want 55", ram_addr); end end
        end
    endtask

    task automatic test_vblank_stream();
        logic [7:0] a;
        a = 8'($urandom);
        vcount = 10'd770; hcount = 11'd200; p1_addr = a;
        for (int k = 0; k < 17; k++) begin
            bit e1;
            tick();
            e1 = (k >= 3) && (k <= 15) && (k % 3 == 0);
            n_cmp++; if (p1_ack !== e1) begin n_fail++; $display("[TB] FAIL vb_p1_ack k=%0d: got %b want %b", k, p1_ack, e1); end
            n_cmp++; if (p0_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL vb_p0_ack k=%0d: got %b want 0", k, p0_ack); end
            if (e1) begin
                n_cmp++; if (p1_data !== (a ^ 8'hA5)) begin n_fail++; $display("[TB] FAIL vb_p1_data k=%0d: got %h want %h", k, p1_data, a ^ 8'hA5); end
            end
            if (k == 0) p1_req = 1'b1;
            if (k == 13) p1_req = 1'b0;
            #1;
            if ((k % 3 == 0) && (k <= 12)) begin
                n_cmp++; if (ram_addr !== a) begin n_fail++; $display("[TB] FAIL vb_grant_addr k=%0d: got %h want %h", k, ram_addr, a); end
            end
        end
    endtask

    task automatic test_random();
        int         free_at = 0;
        int         last = 1;
        int         ack_at = -1;
        int         ack_id = 0;
        int         pick;
        logic [7:0] ack_data = '0;
        bit         rq [2];
        bit         outst [2];
        bit         held_ok [2];
        logic [7:0] ad [2];
        logic [7:0] held [2];
        bit         act_h [4];
        logic [7:0] addr_h [4];
        logic [7:0] last_addr = '0;
        logic [7:0] exp_addr;
        bit         e [2];
        bit         blk, act;
        for (int i = 0; i < 2; i++) begin rq[i] = 0; outst[i] = 0; held_ok[i] = 0; ad[i] = '0; held[i] = '0; end
        for (int k = 0; k < 3000; k++) begin
            tick();
            e[0] = (ack_at == k) && (ack_id == 0);
            e[1] = (ack_at == k) && (ack_id == 1);
            n_cmp++; if (p0_ack !== e[0]) begin n_fail++; $display("[TB] FAIL rnd_p0_ack k=%0d: got %b want %b", k, p0_ack, e[0]); end
            n_cmp++; if (p1_ack !== e[1]) begin n_fail++; $display("[TB] FAIL rnd_p1_ack k=%0d: got %b want %b", k, p1_ack, e[1]); end
            for (int i = 0; i < 2; i++) begin
                if (e[i]) begin held[i] = ack_data; held_ok[i] = 1; outst[i] = 0; rq[i] = 0; end
            end
            if (held_ok[0]) begin n_cmp++; if (p0_data !== held[0]) begin n_fail++; $display("[TB] FAIL rnd_p0_data k=%0d: got %h want %h", k, p0_data, held[0]); end end
            if (held_ok[1]) begin n_cmp++; if (p1_data !== held[1]) begin n_fail++; $display("[TB] FAIL rnd_p1_data k=%0d: got %h want %h", k, p1_data, held[1]); end end
            if (k >= 2) begin
                n_cmp++;
                if (render_valid !== act_h[(k-2)%4]) begin n_fail++; $display("[TB] FAIL rnd_render_valid k=%0d: got %b want %b", k, render_valid, act_h[(k-2)%4]); end
                if (act_h[(k-2)%4]) begin
                    n_cmp++;
                    if (render_data !== (addr_h[(k-2)%4] ^ 8'hA5)) begin n_fail++; $display("[TB] FAIL rnd_render_data k=%0d: got %h want %h", k, render_data, addr_h[(k-2)%4] ^ 8'hA5); end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!rq[i] && !outst[i] && ($urandom_range(0, 2) == 0)) begin
                    rq[i] = 1; ad[i] = 8'($urandom);
                end else if (rq[i] && outst[i] && ($urandom_range(0, 7) == 0)) begin
                    rq[i] = 0;
                end
            end
            p0_req = rq[0]; p0_addr = ad[0];
            p1_req = rq[1]; p1_addr = ad[1];
            act = (k == 0) || ($urandom_range(0, 1) == 0);
            if (act) begin
                hcount = 11'($urandom_range(0, 1023));
                vcount = 10'($urandom_range(0, 767));
            end else if ($urandom_range(0, 1) == 0) begin
                hcount = 11'($urandom_range(1024, 1343));
                vcount = 10'($urandom_range(0, 805));
            end else begin
                hcount = 11'($urandom_range(0, 1343));
                vcount = 10'($urandom_range(768, 805));
            end
            render_addr = 8'($urandom);
            blk = (hcount >= 11'd1024) || (vcount >= 10'd768);
            #1;
            if (!blk) begin
                exp_addr = render_addr;
            end else if ((k >= free_at) && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) pick = (last == 0) ? 1 : 0;
                else pick = rq[1] ? 1 : 0;
                exp_addr = ad[pick];
                last = pick;
                free_at = k + RAM_LAT + 1;
                ack_at = k + RAM_LAT + 1;
                ack_id = pick;
                ack_data = ad[pick] ^ 8'hA5;
                outst[pick] = 1;
            end else begin
                exp_addr = last_addr;
            end
            n_cmp++; if (ram_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL rnd_ram_addr k=%0d: got %h want %h", k, ram_addr, exp_addr); end
            last_addr = exp_addr;
            act_h[k%4] = !blk;
            addr_h[k%4] = exp_addr;
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_renderer();
        test_round_robin();
        test_active_wait();
        test_last_blank_column();
        test_reset_inflight();
        test_vblank_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
